// File: rtl/zclk_monitor_pkg.sv
// rtl/zclk_monitor_pkg.sv - Z80 clock rate codes and nominal periods shared with generator and arbiter.
package zclk_monitor_pkg;

  localparam logic [1:0] TURBO_3M5 = 2'b00;
  localparam logic [1:0] TURBO_7M  = 2'b01;
  localparam logic [1:0] TURBO_14M = 2'b10;

  localparam logic [5:0] PER_3M5 = 6'd8;
  localparam logic [5:0] PER_7M  = 6'd4;
  localparam logic [5:0] PER_14M = 6'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } rate_t;

  function automatic rate_t rate_of_period(input logic [5:0] p);
    rate_t r;
    r.valid = 1'b1;
    r.code  = TURBO_3M5;
    case (p)
      PER_3M5: r.code = TURBO_3M5;
      PER_7M:  r.code = TURBO_7M;
      PER_14M: r.code = TURBO_14M;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zclk_edge_sync.sv
// rtl/zclk_edge_sync.sv - zclk synchronizer chain with rising/falling edge strobes.
module zclk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fclk,
  input  logic rst,
  input  logic zclk,
  output logic zpos,
  output logic zneg
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   zs;
  logic                   zs_d;

  assign zs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge fclk) begin
    if (rst) begin
      sync_q <= '0;
      zs_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], zclk};
      zs_d   <= zs;
    end
  end

  assign zpos = zs & ~zs_d;
  assign zneg = ~zs & zs_d;

endmodule

// File: rtl/zclk_monitor.sv
// rtl/zclk_monitor.sv - Returned Z80 clock monitor: edge strobes, period/duty measurement, rate lock and stall.
module zclk_monitor
  import zclk_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int STALL_CNT   = 63
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       zclk,
  output logic       zpos,
  output logic       zneg,
  output logic [5:0] period,
  output logic [1:0] turbo_det,
  output logic       locked,
  output logic       stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;

  localparam logic [2:0] LOCK_W     = 3'(LOCK_CNT);
  localparam logic [5:0] STALL_PREV = 6'(STALL_CNT - 1);

  state_t     state, state_n;
  logic [5:0] per_cnt, hi_len, period_n;
  logic [2:0] mcnt, mcnt_n;
  logic [1:0] cand, cand_n, turbo_n;
  logic       locked_n, stall_n;
  rate_t      rate;
  logic       meas_valid;

  zclk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .fclk (fclk),
    .rst  (rst),
    .zclk (zclk),
    .zpos (zpos),
    .zneg (zneg)
  );

  // A period only counts when both its length and 50% duty match a nominal rate.
  assign rate       = rate_of_period(per_cnt);
  assign meas_valid = rate.valid && ({hi_len, 1'b0} == {1'b0, per_cnt});

  always_ff @(posedge fclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      per_cnt   <= '0;
      hi_len    <= '0;
      mcnt      <= '0;
      cand      <= TURBO_3M5;
      turbo_det <= TURBO_3M5;
      locked    <= 1'b0;
      stall     <= 1'b0;
      period    <= '0;
    end else begin
      state     <= state_n;
      mcnt      <= mcnt_n;
      cand      <= cand_n;
      turbo_det <= turbo_n;
      locked    <= locked_n;
      stall     <= stall_n;
      period    <= period_n;
      if (zpos)
        per_cnt <= 6'd1;
      else if (per_cnt != 6'd63)
        per_cnt <= per_cnt + 6'd1;
      if (zneg)
        hi_len <= per_cnt;
    end
  end

  always_comb begin
    state_n  = state;
    mcnt_n   = mcnt;
    cand_n   = cand;
    turbo_n  = turbo_det;
    locked_n = locked;
    stall_n  = stall;
    period_n = period;
    if (zpos) begin
      stall_n = 1'b0;
      if (state != ST_IDLE)
        period_n = per_cnt;
      case (state)
        ST_IDLE: begin
          state_n = ST_TRACK;
          mcnt_n  = '0;
        end
        ST_TRACK: begin
          if (!meas_valid) begin
            mcnt_n = '0;
          end else begin
            if (rate.code == cand) begin
              mcnt_n = mcnt + 3'd1;
            end else begin
              cand_n = rate.code;
              mcnt_n = 3'd1;
            end
            if (mcnt_n == LOCK_W) begin
              state_n  = ST_LOCKED;
              turbo_n  = rate.code;
              locked_n = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (!(meas_valid && rate.code == turbo_det)) begin
            state_n  = ST_TRACK;
            locked_n = 1'b0;
            cand_n   = rate.code;
            mcnt_n   = meas_valid ? 3'd1 : 3'd0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (per_cnt == STALL_PREV) begin
      // per_cnt steps onto STALL_CNT at this edge with no rising edge seen.
      state_n  = ST_IDLE;
      locked_n = 1'b0;
      stall_n  = 1'b1;
    end
  end

endmodule

// File: doc/zclk_monitor.md
Name: zclk_monitor

Overview:
- Receive end of the Z80 clock path: samples the zclk returned from the external buffer back into the fclk domain.
- Produces single-cycle zpos/zneg strobes for fclk-domain logic that needs Z80 clock phase.
- Measures period and duty in fclk cycles, classifies the running rate (3.5/7/14 MHz), and flags lock and stall.
- Sits beside the Z80 clock generator; its outputs feed the arbiter, wait-state and inter-clock transfer logic.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for zclk, minimum 2.
- LOCK_CNT, 4: consecutive identical valid periods required to declare lock, range 1..7.
- STALL_CNT, 63: fclk cycles without zpos before declaring stall, range 9..63.

Ports:
- fclk  in  1  system clock, 28 MHz nominal.
- rst  in  1  synchronous reset, active-high.
- zclk  in  1  Z80 clock returned from the external buffer; asynchronous to the sampling point.
- zpos  out  1  one-fclk pulse on each synchronized zclk rising edge.
- zneg  out  1  one-fclk pulse on each synchronized zclk falling edge.
- period  out  6  last measured zclk period in fclk cycles; updated on zpos.
- turbo_det  out  2  detected rate: 00 = 3.5, 01 = 7, 10 = 14 MHz.
- locked  out  1  rate is stable and turbo_det is valid.
- stall  out  1  no zclk rising edge for STALL_CNT cycles.

Behaviour:
- One clock (fclk); reset is synchronous and active-high on rst.
- Reset values:
  - Synchronizer flops, zs_d, period, turbo_det, locked and stall all 0.
  - State is IDLE; internal counters are 0.
- Synchronizer and edge detect:
  - zclk passes through SYNC_STAGES flops; zs is the last stage and zs_d is zs delayed by one cycle.
  - zpos = zs & ~zs_d; zneg = ~zs & zs_d. Both are registered-free decodes of flops.
  - Latency: a zclk change sampled at fclk edge k gives a strobe during cycle k+SYNC_STAGES.
  - If zclk is high at reset release, one zpos occurs.
- Counters:
  - per_cnt is 6 bits. It loads 1 on zpos and otherwise increments, saturating at 63.
  - hi_len is 6 bits and captures per_cnt on zneg.
- Classification, evaluated on zpos using p = per_cnt:
  - A period is valid when p is 2, 4 or 8 and hi_len*2 == p.
  - Valid class: p = 8 gives 00, p = 4 gives 01, p = 2 gives 10.
  - Any other p or duty is invalid.
  - period <= p on every zpos except the first zpos out of IDLE.
- FSM:
  - IDLE:
    - On zpos go to TRACK with mcnt = 0.
    - No measurement is taken; per_cnt loads 1.
  - TRACK, on zpos:
    - Invalid: mcnt <= 0.
    - Valid and equal to cand: mcnt++.
    - Otherwise: cand <= class and mcnt <= 1.
    - When the updated mcnt equals LOCK_CNT: go to LOCKED, turbo_det <= cand, locked <= 1 in the same cycle.
  - LOCKED, on zpos:
    - Valid and equal to turbo_det: stay.
    - Otherwise: go to TRACK, locked <= 0, turbo_det holds its value, cand <= class, mcnt <= (valid ? 1 : 0).
  - Any state:
    - When per_cnt reaches STALL_CNT without zpos: go to IDLE, locked <= 0, stall <= 1.
    - stall clears on the next zpos.
- Simultaneous events:
  - zpos in the same cycle as the stall threshold: zpos wins and stall is not set.
  - rst overrides everything.
  - Reset mid-lock: locked, stall, turbo_det and period are 0 in the cycle after rst is sampled.
- A turbo switch in the generator shows as one or more invalid or mismatched periods. locked must drop no later than the first zpos after the change.

Decomposition:
- Shared include: rate codes TURBO_3M5 = 2'b00, TURBO_7M = 2'b01, TURBO_14M = 2'b10, and nominal periods 8/4/2. These are shared with the clock generator and arbiter.
- FSM state encoding stays local.
- One natural sub-module: zclk_edge_sync, holding the synchronizer chain plus zpos/zneg decode, parameterized by SYNC_STAGES.

Test Plan:
- 3.5 MHz (zclk 4 high / 4 low from reset) -> zpos every 8 cycles, period = 8; locked rises at the 5th zpos (1 entry + 4 matches) with turbo_det = 00.
- Locked at 3.5, switch to 7 MHz (2/2) -> locked = 0 by the first zpos after the switch; relocks with turbo_det = 01, period = 4.
- 14 MHz (1/1) with SYNC_STAGES = 2 -> zpos and zneg alternate every cycle, period = 2, turbo_det = 10, locked = 1.
- Bad duty (3 high / 5 low) -> period = 8 but locked never asserts; mcnt stays 0.
- Locked, then hold zclk low for 70 cycles -> stall = 1 and locked = 0 exactly 63 cycles after the last zpos. Resuming toggling gives stall = 0 on the first zpos and no period update on that edge.
- Assert rst for 1 cycle while locked at 7 MHz -> all outputs 0 the next cycle; relock follows the normal sequence.
